dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates the single-port data RAM between two requesters: the core MEM stage and a debug/loader port, which the host uses to peek and poke data memory while the core runs.
- Sits between the EX/MEM pipeline register outputs and the data RAM.
- Returns a stall to the pipeline whenever the core's access cannot finish in the current cycle.
- Writes take 1 cycle; reads take 2 cycles (issue, then data).

Parameters:
- ADDR_W, 32, address width of both requesters and the RAM.
- DATA_W, 32, data width.
- STARVE_MAX, 4, number of consecutive core grants allowed while dbg_req is pending; the next grant goes to debug.

Ports:
- clk  in  1  clock for all state in the block.
- rst  in  1  asynchronous, active-high reset.
- core_req  in  1  core MEM-stage access request (mem_r | mem_w); held until core_stall is low.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  ADDR_W  byte address.
- core_wdata  in  DATA_W  store data.
- core_ubhw  in  3  funct3 size/sign code, passed to the RAM.
- core_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- core_rdata  out  DATA_W  load data, valid when core_rvalid = 1.
- core_rvalid  out  1  load data valid.
- dbg_req  in  1  debug access request; held until dbg_gnt.
- dbg_we  in  1  debug write.
- dbg_addr  in  ADDR_W  debug byte address; word accesses only.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_gnt  out  1  1-cycle pulse in the cycle the debug command is issued to the RAM.
- dbg_rdata  out  DATA_W  debug read data.
- dbg_rvalid  out  1  debug read data valid.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_ubhw  out  3  RAM size code.
- ram_rdata  in  DATA_W  RAM read data; valid the cycle after ram_re.
- busy  out  1  1 when state != IDLE.

Behaviour:
- State machine: IDLE, RD_CORE, RD_DBG. All outputs are combinational from state and inputs. Only state and starve_cnt are registered.
- Reset (async, rst = 1):
  - state = IDLE, starve_cnt = 0.
  - While rst is high: ram_we = ram_re = 0, dbg_gnt = 0, core_stall = 0, both rvalid = 0, busy = 0.
- IDLE, arbitration in the same cycle:
  - dbg wins if dbg_req & (~core_req | starve_cnt == STARVE_MAX).
  - Otherwise core wins if core_req.
  - The winner's addr, wdata and we are driven to the RAM. ram_re = ~we.
  - ram_ubhw = core_ubhw for core, 3'b010 for debug.
- Core write wins: core_stall = 0; the store completes this cycle; state stays IDLE.
- Core read wins: core_stall = 1; next state = RD_CORE.
- RD_CORE:
  - core_rdata = ram_rdata, core_rvalid = 1, core_stall = 0.
  - ram_we = ram_re = 0.
  - Next state = IDLE.
- Debug wins:
  - dbg_gnt = 1; core_stall = core_req.
  - Write: stay IDLE.
  - Read: next state = RD_DBG.
- RD_DBG:
  - dbg_rdata = ram_rdata, dbg_rvalid = 1.
  - No RAM issue this cycle; core_stall = core_req.
  - Next state = IDLE.
- Outside the read-data states, core_rdata, dbg_rdata and both rvalid are 0.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when core wins while dbg_req = 1.
  - Cleared when debug wins or when dbg_req = 0.
- Idle cycles: no request means no RAM enables and core_stall = 0.
- Simultaneous core write and debug request with starve_cnt < STARVE_MAX: core wins, dbg_gnt = 0.
- Reset mid-read (in RD_CORE or RD_DBG): the state returns to IDLE immediately, and the pending rvalid is never asserted.
- Requester obligations (precondition, not checked by the block):
  - Requesters must hold all request fields stable until granted.
  - The block has no abort: core_req must not fall while core_stall is high, unless the exception unit flushes EX/MEM.
  - A flush that drops core_req while state = RD_CORE still completes the data cycle; core_rvalid is asserted and ignored.

Test Plan:
- Core load, addr 0x10, RAM returns 0xDEADBEEF, no debug traffic:
  - Cycle 0: ram_re = 1, core_stall = 1.
  - Cycle 1: core_rvalid = 1, core_rdata = 0xDEADBEEF, core_stall = 0.
- Core store 0x12345678 @0x20: ram_we = 1 in the same cycle, core_stall = 0, busy stays 0.
- Debug write 0xA5A5A5A5 @0x40 with core idle: dbg_gnt pulses, ram_ubhw = 3'b010. A following debug read returns 0xA5A5A5A5 with dbg_rvalid = 1 one cycle after its grant.
- Core stores every cycle with dbg_req held high, STARVE_MAX = 4: the core is granted 4 times, then dbg_gnt = 1 on the 5th arbitration with core_stall = 1, and starve_cnt returns to 0.
- rst asserted in RD_CORE: state goes to IDLE asynchronously, core_rvalid = 0, ram_re = 0. After rst is released, a new load completes normally in 2 cycles.
- Debug read issued while core_req (load) arrives: core_stall stays 1 through the issue and RD_DBG cycles. The core load is then issued in the next cycle and completes one cycle later.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data RAM arbiter between core MEM stage and debug/loader port
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // core MEM stage
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [2:0]        core_ubhw,
  output logic              core_stall,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  // debug / loader port
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  // data RAM
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [2:0]        ram_ubhw,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [2:0] UBHW_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CORE = 2'd1,
    RD_DBG  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             dbg_win, core_win;

  // State and starvation counter registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Arbitration, RAM command mux, read-data return and next-state logic.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    dbg_win      = 1'b0;
    core_win     = 1'b0;
    core_stall   = 1'b0;
    core_rdata   = '0;
    core_rvalid  = 1'b0;
    dbg_gnt      = 1'b0;
    dbg_rdata    = '0;
    dbg_rvalid   = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_ubhw     = '0;
    busy         = 1'b0;

    // Everything stays quiet while reset is held, even with requests pending.
    if (!rst) begin
      busy = (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          // Debug only preempts a waiting core once the core has had its quota.
          dbg_win  = dbg_req & (~core_req | (starve_cnt_q == STARVE_LIM));
          core_win = ~dbg_win & core_req;
          if (dbg_win) begin
            dbg_gnt    = 1'b1;
            core_stall = core_req;
            ram_addr   = dbg_addr;
            ram_wdata  = dbg_wdata;
            ram_we     = dbg_we;
            ram_re     = ~dbg_we;
            ram_ubhw   = UBHW_WORD;
            if (!dbg_we) state_d = RD_DBG;
          end else if (core_win) begin
            core_stall = ~core_we;
            ram_addr   = core_addr;
            ram_wdata  = core_wdata;
            ram_we     = core_we;
            ram_re     = ~core_we;
            ram_ubhw   = core_ubhw;
            if (!core_we) state_d = RD_CORE;
          end
        end
        RD_CORE: begin
          core_rdata  = ram_rdata;
          core_rvalid = 1'b1;
          state_d     = IDLE;
        end
        RD_DBG: begin
          dbg_rdata  = ram_rdata;
          dbg_rvalid = 1'b1;
          core_stall = core_req;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (dbg_win || !dbg_req) begin
        starve_cnt_d = '0;
      end else if (core_win && starve_cnt_q != STARVE_LIM) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_ubhw;
  logic        core_stall, core_rvalid;
  logic [31:0] core_rdata;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [31:0] ram_addr, ram_wdata;
  logic        ram_we, ram_re;
  logic [2:0]  ram_ubhw;
  logic [31:0] ram_rdata = '0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ubhw(core_ubhw), .core_stall(core_stall),
    .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .dbg_rvalid(dbg_rvalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_re(ram_re), .ram_ubhw(ram_ubhw), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Bench RAM: command latched mid-cycle, applied at the clock edge.
  logic [31:0] ram_mem [logic [31:0]];
  logic        l_we, l_re;
  logic [31:0] l_addr, l_wdata;
  always @(negedge clk) begin
    l_we = ram_we; l_re = ram_re; l_addr = ram_addr; l_wdata = ram_wdata;
  end
  always @(posedge clk) begin
    if (l_we) ram_mem[l_addr] = l_wdata;
    if (l_re) ram_rdata <= ram_mem.exists(l_addr) ? ram_mem[l_addr] : 32'h0;
  end

  // Reference model: who owns an outstanding read, its address, starvation tally, memory image.
  int          m_pend;      // 0 none, 1 core read outstanding, 2 debug read outstanding
  logic [31:0] m_raddr;
  int          m_starve;
  logic [31:0] m_mem [logic [31:0]];
  logic        e_stall, e_crv, e_drv, e_gnt, e_we, e_re, e_busy, d_win, c_win;
  logic [31:0] e_crd, e_drd, e_addr, e_wdata;
  logic [2:0]  e_ubhw;

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return m_mem.exists(a) ? m_mem[a] : 32'h0;
  endfunction

  initial begin
    m_pend = 0; m_starve = 0; m_raddr = '0;
  end

  always @(negedge clk) begin
    e_stall = 0; e_crv = 0; e_drv = 0; e_gnt = 0; e_we = 0; e_re = 0; e_busy = 0;
    e_crd = 0; e_drd = 0; e_addr = 0; e_wdata = 0; e_ubhw = 0; d_win = 0; c_win = 0;
    if (rst) begin
      m_pend = 0; m_starve = 0;
    end else if (m_pend == 1) begin
      e_crv = 1; e_crd = mrd(m_raddr); e_busy = 1; m_pend = 0;
    end else if (m_pend == 2) begin
      e_drv = 1; e_drd = mrd(m_raddr); e_busy = 1; e_stall = core_req; m_pend = 0;
    end else begin
      d_win = dbg_req && (!core_req || m_starve == SM);
      c_win = !d_win && core_req;
      if (d_win) begin
        e_gnt = 1; e_stall = core_req; e_addr = dbg_addr; e_wdata = dbg_wdata;
        e_we = dbg_we; e_re = !dbg_we; e_ubhw = 3'b010;
      end else if (c_win) begin
        e_stall = !core_we; e_addr = core_addr; e_wdata = core_wdata;
        e_we = core_we; e_re = !core_we; e_ubhw = core_ubhw;
      end
      if (e_we) m_mem[e_addr] = e_wdata;
      if (e_re) begin m_pend = d_win ? 2 : 1; m_raddr = e_addr; end
    end
    if (!rst) begin
      if (d_win || !dbg_req) m_starve = 0;
      else if (c_win && m_starve < SM) m_starve++;
    end
    chk("core_stall", core_stall, e_stall);
    chk("core_rvalid", core_rvalid, e_crv);
    chk("core_rdata", core_rdata, e_crd);
    chk("dbg_gnt", dbg_gnt, e_gnt);
    chk("dbg_rvalid", dbg_rvalid, e_drv);
    chk("dbg_rdata", dbg_rdata, e_drd);
    chk("ram_we", ram_we, e_we);
    chk("ram_re", ram_re, e_re);
    chk("busy", busy, e_busy);
    if (e_we || e_re) begin
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_ubhw", ram_ubhw, e_ubhw);
    end
    if (e_we) chk("ram_wdata", ram_wdata, e_wdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus with hand-computed literal expectations.
  initial begin
    ram_mem[32'h10] = 32'hDEADBEEF;
    m_mem[32'h10]   = 32'hDEADBEEF;
    rst = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10; core_wdata = '0; core_ubhw = 3'b010;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    // Reset holds all enables low even with a core load pending.
    @(negedge clk);
    chk("rst_ram_re", ram_re, 1'b0);
    chk("rst_stall", core_stall, 1'b0);
    chk("rst_busy", busy, 1'b0);
    step();
    rst = 1'b0;

    // Core load of 0x10.
    @(negedge clk);
    chk("ld_issue_re", ram_re, 1'b1);
    chk("ld_issue_stall", core_stall, 1'b1);
    step();
    core_req = 1'b0;
    @(negedge clk);
    chk("ld_rvalid", core_rvalid, 1'b1);
    chk("ld_rdata", core_rdata, 32'hDEADBEEF);
    chk("ld_stall", core_stall, 1'b0);
    step();

    // Idle cycle.
    @(negedge clk);
    chk("idle_re", ram_re, 1'b0);
    step();

    // Core store 0x12345678 @0x20.
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'h12345678;
    @(negedge clk);
    chk("st_we", ram_we, 1'b1);
    chk("st_stall", core_stall, 1'b0);
    chk("st_busy", busy, 1'b0);
    step();
    core_req = 1'b0;

    // Debug write then debug read of 0x40.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("dw_gnt", dbg_gnt, 1'b1);
    chk("dw_ubhw", ram_ubhw, 3'b010);
    step();
    dbg_we = 1'b0;
    @(negedge clk);
    chk("dr_gnt", dbg_gnt, 1'b1);
    step();
    dbg_req = 1'b0;
    @(negedge clk);
    chk("dr_rvalid", dbg_rvalid, 1'b1);
    chk("dr_rdata", dbg_rdata, 32'hA5A5A5A5);
    step();

    // Back-to-back core stores with debug write pending: 4 core grants, then debug.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h44; dbg_wdata = 32'h11111111;
    core_req = 1'b1; core_we = 1'b1;
    for (int i = 0; i < SM; i++) begin
      core_addr = 32'h80 + 32'(i * 4); core_wdata = 32'hC0DE0000 + 32'(i);
      @(negedge clk);
      chk("starve_core_we", ram_we, 1'b1);
      chk("starve_no_gnt", dbg_gnt, 1'b0);
      chk("starve_addr", ram_addr, 32'h80 + 32'(i * 4));
      step();
    end
    core_addr = 32'h90; core_wdata = 32'hC0DE0004;
    @(negedge clk);
    chk("starve_gnt", dbg_gnt, 1'b1);
    chk("starve_stall", core_stall, 1'b1);
    chk("starve_dbg_addr", ram_addr, 32'h44);
    step();
    dbg_req = 1'b0;
    @(negedge clk);
    chk("after_starve_core", ram_we, 1'b1);
    chk("after_starve_addr", ram_addr, 32'h90);
    step();
    core_req = 1'b0;

    // Reset asserted while in RD_CORE.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
    step();
    rst = 1'b1; core_req = 1'b0;
    @(negedge clk);
    chk("rstrd_rvalid", core_rvalid, 1'b0);
    chk("rstrd_busy", busy, 1'b0);
    chk("rstrd_re", ram_re, 1'b0);
    step();
    rst = 1'b0;
    core_req = 1'b1; core_addr = 32'h20;
    @(negedge clk);
    chk("post_rst_re", ram_re, 1'b1);
    step();
    core_req = 1'b0;
    @(negedge clk);
    chk("post_rst_rdata", core_rdata, 32'h12345678);
    chk("post_rst_rvalid", core_rvalid, 1'b1);
    step();

    // Debug read wins against a waiting core load after 4 core loads.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10; core_ubhw = 3'b100;
    for (int i = 0; i < SM; i++) begin
      @(negedge clk);
      chk("cl_no_gnt", dbg_gnt, 1'b0);
      step();
      @(negedge clk);
      chk("cl_rdata", core_rdata, 32'hDEADBEEF);
      step();
    end
    @(negedge clk);
    chk("dbgrd_gnt", dbg_gnt, 1'b1);
    chk("dbgrd_stall_issue", core_stall, 1'b1);
    step();
    dbg_req = 1'b0;
    @(negedge clk);
    chk("dbgrd_rdata", dbg_rdata, 32'hA5A5A5A5);
    chk("dbgrd_stall_rd", core_stall, 1'b1);
    step();
    @(negedge clk);
    chk("late_core_re", ram_re, 1'b1);
    chk("late_core_ubhw", ram_ubhw, 3'b100);
    step();
    core_req = 1'b0;
    @(negedge clk);
    chk("late_core_rvalid", core_rvalid, 1'b1);
    chk("late_core_rdata", core_rdata, 32'hDEADBEEF);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
